// File: rtl/rf_wb_arbiter_pkg.sv
// Shared widths, the zero-register constant and the FIFO entry layout
// for the register-file write-back arbiter.
package rf_wb_arbiter_pkg;

   localparam int REG_ADDR_W = 5;
   localparam int DATA_W     = 32;

   localparam logic [REG_ADDR_W-1:0] ZERO_REG = 5'd0;

   // One buffered long-unit result; live=0 means the entry is popped without an RF write.
   typedef struct packed {
      logic                  live;
      logic [REG_ADDR_W-1:0] wr;
      logic [DATA_W-1:0]     wd;
   } wb_entry_t;

   localparam wb_entry_t ENTRY_NULL = '{live: 1'b0, wr: 5'd0, wd: 32'd0};

   // True when an entry will still write register r.
   function automatic logic live_match(input wb_entry_t e, input logic [REG_ADDR_W-1:0] r);
      return e.live && (e.wr == r);
   endfunction

endpackage

// File: rtl/rf_wb_arbiter_if.sv
// Bus bundle between the write-back sources, decode and the arbiter.
// The arbiter takes the slave view; the surrounding pipeline the master view.
interface rf_wb_arbiter_if;
   import rf_wb_arbiter_pkg::*;

   logic                  pipe_we;
   logic [REG_ADDR_W-1:0] pipe_wR;
   logic [DATA_W-1:0]     pipe_wD;
   logic                  lu_valid;
   logic                  lu_ready;
   logic [REG_ADDR_W-1:0] lu_wR;
   logic [DATA_W-1:0]     lu_wD;
   logic                  we;
   logic [REG_ADDR_W-1:0] wR;
   logic [DATA_W-1:0]     wD;
   logic [REG_ADDR_W-1:0] rR1;
   logic [REG_ADDR_W-1:0] rR2;
   logic                  busy1;
   logic                  busy2;
   logic                  pipe_stall;

   modport slave (
      input  pipe_we, pipe_wR, pipe_wD,
      input  lu_valid, lu_wR, lu_wD,
      output lu_ready,
      output we, wR, wD,
      input  rR1, rR2,
      output busy1, busy2,
      output pipe_stall
   );

   modport master (
      output pipe_we, pipe_wR, pipe_wD,
      output lu_valid, lu_wR, lu_wD,
      input  lu_ready,
      input  we, wR, wD,
      output rR1, rR2,
      input  busy1, busy2,
      input  pipe_stall
   );

endinterface

// File: rtl/rf_wb_arbiter_wb_fifo.sv
// Long-unit result FIFO with per-entry live bits, a kill-by-address port
// that clears live bits of stale entries, and per-entry pending-match
// vectors for the two decode source queries.
module rf_wb_arbiter_wb_fifo
   import rf_wb_arbiter_pkg::*;
#(
   parameter int DEPTH = 4
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  push,
   input  logic                  push_live,
   input  logic [REG_ADDR_W-1:0] push_wr,
   input  logic [DATA_W-1:0]     push_wd,
   input  logic                  pop,
   input  logic                  kill_en,
   input  logic [REG_ADDR_W-1:0] kill_wr,
   input  logic [REG_ADDR_W-1:0] q1_wr,
   input  logic [REG_ADDR_W-1:0] q2_wr,
   output wb_entry_t             head,
   output logic                  empty,
   output logic                  full,
   output logic [DEPTH-1:0]      match1,
   output logic [DEPTH-1:0]      match2
);

   localparam int PTR_W = $clog2(DEPTH);
   localparam int CNT_W = PTR_W + 1;

   wb_entry_t        mem_q [DEPTH];
   wb_entry_t        mem_d [DEPTH];
   logic [PTR_W-1:0] head_q, head_d;
   logic [PTR_W-1:0] tail_q, tail_d;
   logic [CNT_W-1:0] count_q, count_d;
   logic [PTR_W-1:0] off_s [DEPTH];
   logic [DEPTH-1:0] occ_s;
   logic             push_ok_s;
   logic             pop_ok_s;

   assign empty = (count_q == CNT_W'(0));
   assign full  = (count_q == CNT_W'(DEPTH));
   assign head  = mem_q[head_q];

   // Next-state for storage, pointers and count, including the WAW kill.
   always_comb begin
      push_ok_s = push && !full;
      pop_ok_s  = pop && !empty;
      mem_d     = mem_q;
      for (int i = 0; i < DEPTH; i++) begin
         if (kill_en && (mem_q[i].wr == kill_wr)) begin
            mem_d[i].live = 1'b0;
         end else begin
            mem_d[i].live = mem_q[i].live;
         end
      end
      // The incoming entry lands after the kill so its own live bit is decided by the caller.
      if (push_ok_s) begin
         mem_d[tail_q] = '{live: push_live, wr: push_wr, wd: push_wd};
         tail_d        = tail_q + PTR_W'(1);
      end else begin
         tail_d = tail_q;
      end
      if (pop_ok_s) begin
         head_d = head_q + PTR_W'(1);
      end else begin
         head_d = head_q;
      end
      case ({push_ok_s, pop_ok_s})
         2'b10:   count_d = count_q + CNT_W'(1);
         2'b01:   count_d = count_q - CNT_W'(1);
         default: count_d = count_q;
      endcase
   end

   // Occupancy window [head, head+count) and live-address matches for decode.
   always_comb begin
      for (int i = 0; i < DEPTH; i++) begin
         off_s[i]  = PTR_W'(i) - head_q;
         occ_s[i]  = ({1'b0, off_s[i]} < count_q);
         match1[i] = occ_s[i] && live_match(mem_q[i], q1_wr);
         match2[i] = occ_s[i] && live_match(mem_q[i], q2_wr);
      end
   end

   // State registers; reset discards every entry.
   always_ff @(posedge clk) begin
      if (rst) begin
         head_q  <= PTR_W'(0);
         tail_q  <= PTR_W'(0);
         count_q <= CNT_W'(0);
         for (int i = 0; i < DEPTH; i++) begin
            mem_q[i] <= ENTRY_NULL;
         end
      end else begin
         head_q  <= head_d;
         tail_q  <= tail_d;
         count_q <= count_d;
         for (int i = 0; i < DEPTH; i++) begin
            mem_q[i] <= mem_d[i];
         end
      end
   end

endmodule

// File: rtl/rf_wb_arbiter.sv
// Write-back arbiter in front of the single register-file write port.
// The in-order pipeline always wins; buffered long-unit results drain in
// idle cycles, and a starve counter asks upstream to yield when needed.
module rf_wb_arbiter
   import rf_wb_arbiter_pkg::*;
#(
   parameter int DEPTH      = 4,
   parameter int STARVE_MAX = 8
) (
   input  logic            cpu_clk,
   input  logic            cpu_rst,
   rf_wb_arbiter_if.slave  bus
);

   localparam int ST_W = $clog2(STARVE_MAX + 1);

   logic             pipe_win_s;
   logic             push_s;
   logic             push_live_s;
   logic             pop_s;
   logic             fifo_empty_s;
   logic             fifo_full_s;
   wb_entry_t        head_s;
   logic [DEPTH-1:0] match1_s;
   logic [DEPTH-1:0] match2_s;
   logic [ST_W-1:0]  starve_q, starve_d;

   rf_wb_arbiter_wb_fifo #(.DEPTH(DEPTH)) u_fifo (
      .clk       (cpu_clk),
      .rst       (cpu_rst),
      .push      (push_s),
      .push_live (push_live_s),
      .push_wr   (bus.lu_wR),
      .push_wd   (bus.lu_wD),
      .pop       (pop_s),
      .kill_en   (pipe_win_s),
      .kill_wr   (bus.pipe_wR),
      .q1_wr     (bus.rR1),
      .q2_wr     (bus.rR2),
      .head      (head_s),
      .empty     (fifo_empty_s),
      .full      (fifo_full_s),
      .match1    (match1_s),
      .match2    (match2_s)
   );

   // Source arbitration, enqueue handshake and the RF write port.
   always_comb begin
      pipe_win_s = bus.pipe_we && (bus.pipe_wR != ZERO_REG);
      // Ready depends only on registered fullness, so a full FIFO refuses even while popping.
      bus.lu_ready = !cpu_rst && !fifo_full_s;
      push_s       = bus.lu_valid && bus.lu_ready;
      // A same-cycle pipeline write to the same register is newer, so the entry is born dead.
      push_live_s  = (bus.lu_wR != ZERO_REG) &&
                     !(pipe_win_s && (bus.pipe_wR == bus.lu_wR));
      pop_s        = !cpu_rst && !pipe_win_s && !fifo_empty_s;
      if (cpu_rst) begin
         bus.we = 1'b0;
         bus.wR = ZERO_REG;
         bus.wD = 32'd0;
      end else if (pipe_win_s) begin
         bus.we = 1'b1;
         bus.wR = bus.pipe_wR;
         bus.wD = bus.pipe_wD;
      end else if (pop_s && head_s.live) begin
         bus.we = 1'b1;
         bus.wR = head_s.wr;
         bus.wD = head_s.wd;
      end else begin
         bus.we = 1'b0;
         bus.wR = ZERO_REG;
         bus.wD = 32'd0;
      end
   end

   // Pending flags for decode; an entry popping this cycle is still pending.
   always_comb begin
      if (cpu_rst) begin
         bus.busy1 = 1'b0;
         bus.busy2 = 1'b0;
      end else begin
         bus.busy1 = (bus.rR1 != ZERO_REG) && (|match1_s);
         bus.busy2 = (bus.rR2 != ZERO_REG) && (|match2_s);
      end
   end

   // Starve counter next state: count lost arbitrations, saturate, clear on pop/empty.
   always_comb begin
      if (fifo_empty_s) begin
         starve_d = ST_W'(0);
      end else if (pop_s) begin
         starve_d = ST_W'(0);
      end else if (starve_q != ST_W'(STARVE_MAX)) begin
         starve_d = starve_q + ST_W'(1);
      end else begin
         starve_d = starve_q;
      end
      bus.pipe_stall = !cpu_rst && (starve_q == ST_W'(STARVE_MAX));
   end

   // Starve counter register.
   always_ff @(posedge cpu_clk) begin
      if (cpu_rst) begin
         starve_q <= ST_W'(0);
      end else begin
         starve_q <= starve_d;
      end
   end

endmodule

// File: tb/tb_rf_wb_arbiter.sv
// Directed bench for rf_wb_arbiter: expected RF writes are queued when the
// stimulus is issued; a monitor compares every asserted write against it.
module tb_rf_wb_arbiter;

   logic clk = 1'b0;
   logic rst;

   rf_wb_arbiter_if bus();

   rf_wb_arbiter #(.DEPTH(4), .STARVE_MAX(8)) dut (
      .cpu_clk (clk),
      .cpu_rst (rst),
      .bus     (bus)
   );

   always #5 clk = ~clk;

   int          n_tests = 0;
   int          n_fail  = 0;
   logic [36:0] exp_q[$];
   logic [36:0] mon_e;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h, required %0h", name, act, exp);
      end
   endtask

   task automatic push_exp(input logic [4:0] r, input logic [31:0] d);
      exp_q.push_back({r, d});
   endtask

   task automatic next();
      @(posedge clk);
      #1;
   endtask

   task automatic smp();
      @(negedge clk);
   endtask

   task automatic idle();
      bus.pipe_we  = 1'b0;
      bus.pipe_wR  = 5'd0;
      bus.pipe_wD  = 32'd0;
      bus.lu_valid = 1'b0;
      bus.lu_wR    = 5'd0;
      bus.lu_wD    = 32'd0;
   endtask

   // Scoreboard monitor: every RF write must be the next expected one.
   always @(negedge clk) begin
      if (bus.we === 1'b1) begin
         if (exp_q.size() == 0) begin
            n_tests++;
            n_fail++;
            $display("FAIL unexpected_write: got r%0d=%08h, required no write", bus.wR, bus.wD);
         end else begin
            mon_e = exp_q.pop_front();
            chk("rf_write", {27'd0, bus.wR, bus.wD}, {27'd0, mon_e});
         end
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish, required finish");
      $fatal(1, "watchdog");
   end

   initial begin
      // Reset with active inputs: every output forced low.
      rst = 1'b1;
      idle();
      bus.rR1 = 5'd3; bus.rR2 = 5'd0;
      bus.pipe_we = 1'b1; bus.pipe_wR = 5'd3; bus.pipe_wD = 32'h1;
      bus.lu_valid = 1'b1; bus.lu_wR = 5'd3;
      smp();
      chk("rst_we", bus.we, 1'b0);
      chk("rst_wR", bus.wR, 5'd0);
      chk("rst_wD", bus.wD, 32'd0);
      chk("rst_ready", bus.lu_ready, 1'b0);
      chk("rst_busy1", bus.busy1, 1'b0);
      chk("rst_stall", bus.pipe_stall, 1'b0);
      next();
      rst = 1'b0;
      idle();

      // 1: single long-unit result, one-cycle latency, busy window.
      push_exp(5'd5, 32'h1234);
      bus.lu_valid = 1'b1; bus.lu_wR = 5'd5; bus.lu_wD = 32'h1234; bus.rR1 = 5'd5;
      smp();
      chk("t1_ready", bus.lu_ready, 1'b1);
      chk("t1_busy_before", bus.busy1, 1'b0);
      chk("t1_no_write_yet", bus.we, 1'b0);
      next();
      bus.lu_valid = 1'b0;
      smp();
      chk("t1_we", bus.we, 1'b1);
      chk("t1_busy_during", bus.busy1, 1'b1);
      next();
      smp();
      chk("t1_busy_after", bus.busy1, 1'b0);
      chk("t1_we_after", bus.we, 1'b0);
      next();

      // 2: fill under pipeline pressure, full backpressure, in-order drain.
      for (int i = 0; i < 4; i++) push_exp(5'(i + 1), 32'h2000 + 32'(i));
      for (int i = 0; i < 5; i++) push_exp(5'(i + 10), 32'h100 + 32'(i));
      for (int i = 0; i < 4; i++) begin
         bus.pipe_we = 1'b1; bus.pipe_wR = 5'(i + 1); bus.pipe_wD = 32'h2000 + 32'(i);
         bus.lu_valid = 1'b1; bus.lu_wR = 5'(i + 10); bus.lu_wD = 32'h100 + 32'(i);
         smp();
         chk("t2_ready_fill", bus.lu_ready, 1'b1);
         chk("t2_pipe_we", bus.we, 1'b1);
         next();
      end
      bus.pipe_we = 1'b0; bus.lu_wR = 5'd14; bus.lu_wD = 32'h104;
      smp();
      chk("t2_ready_full", bus.lu_ready, 1'b0);
      chk("t2_drain0", bus.we, 1'b1);
      next();
      smp();
      chk("t2_ready_again", bus.lu_ready, 1'b1);
      chk("t2_drain1", bus.we, 1'b1);
      next();
      bus.lu_valid = 1'b0;
      for (int i = 0; i < 3; i++) begin
         smp();
         chk("t2_drain_tail", bus.we, 1'b1);
         next();
      end
      smp();
      chk("t2_empty", bus.we, 1'b0);
      next();

      // 3: queued r7 killed by a later pipeline write to r7.
      push_exp(5'd7, 32'hB);
      bus.lu_valid = 1'b1; bus.lu_wR = 5'd7; bus.lu_wD = 32'hA; bus.rR1 = 5'd7;
      smp();
      chk("t3_busy_before", bus.busy1, 1'b0);
      next();
      bus.lu_valid = 1'b0;
      bus.pipe_we = 1'b1; bus.pipe_wR = 5'd7; bus.pipe_wD = 32'hB;
      smp();
      chk("t3_busy_pending", bus.busy1, 1'b1);
      chk("t3_pipe_we", bus.we, 1'b1);
      next();
      idle();
      smp();
      chk("t3_dead_pop_we", bus.we, 1'b0);
      chk("t3_busy_killed", bus.busy1, 1'b0);
      next();
      smp();
      chk("t3_idle_we", bus.we, 1'b0);
      next();

      // 4: same-cycle long-unit and pipeline write to r9.
      push_exp(5'd9, 32'hD);
      bus.lu_valid = 1'b1; bus.lu_wR = 5'd9; bus.lu_wD = 32'hC; bus.rR2 = 5'd9;
      bus.pipe_we = 1'b1; bus.pipe_wR = 5'd9; bus.pipe_wD = 32'hD;
      smp();
      chk("t4_ready", bus.lu_ready, 1'b1);
      chk("t4_pipe_we", bus.we, 1'b1);
      next();
      idle();
      smp();
      chk("t4_busy2_dead", bus.busy2, 1'b0);
      chk("t4_dead_pop_we", bus.we, 1'b0);
      next();
      smp();
      chk("t4_idle_we", bus.we, 1'b0);
      next();

      // 5: starvation: stall after 8 lost cycles, hold on violation, clear after pop.
      for (int i = 0; i < 9; i++) push_exp(5'd20, 32'h200 + 32'(i));
      push_exp(5'd12, 32'h55);
      bus.lu_valid = 1'b1; bus.lu_wR = 5'd12; bus.lu_wD = 32'h55;
      smp();
      next();
      bus.lu_valid = 1'b0;
      for (int i = 0; i < 8; i++) begin
         bus.pipe_we = 1'b1; bus.pipe_wR = 5'd20; bus.pipe_wD = 32'h200 + 32'(i);
         smp();
         chk("t5_no_stall", bus.pipe_stall, 1'b0);
         next();
      end
      bus.pipe_wD = 32'h208;
      smp();
      chk("t5_stall", bus.pipe_stall, 1'b1);
      chk("t5_violation_we", bus.we, 1'b1);
      next();
      bus.pipe_we = 1'b0;
      smp();
      chk("t5_stall_hold", bus.pipe_stall, 1'b1);
      chk("t5_drain_we", bus.we, 1'b1);
      next();
      smp();
      chk("t5_stall_clear", bus.pipe_stall, 1'b0);
      chk("t5_idle_we", bus.we, 1'b0);
      next();

      // 6a: r0 writes from both sources never reach the RF.
      bus.rR1 = 5'd0;
      bus.lu_valid = 1'b1; bus.lu_wR = 5'd0; bus.lu_wD = 32'hDEAD;
      bus.pipe_we = 1'b1; bus.pipe_wR = 5'd0; bus.pipe_wD = 32'hBEEF;
      smp();
      chk("t6_r0_we", bus.we, 1'b0);
      chk("t6_r0_ready", bus.lu_ready, 1'b1);
      chk("t6_r0_busy", bus.busy1, 1'b0);
      next();
      bus.lu_valid = 1'b0;
      smp();
      chk("t6_r0_pop_we", bus.we, 1'b0);
      next();
      idle();
      smp();
      chk("t6_r0_idle_we", bus.we, 1'b0);
      next();

      // 6b: reset with three entries queued discards them all.
      for (int i = 0; i < 3; i++) push_exp(5'd21, 32'h300 + 32'(i));
      bus.rR1 = 5'd15;
      for (int i = 0; i < 3; i++) begin
         bus.lu_valid = 1'b1; bus.lu_wR = 5'(i + 15); bus.lu_wD = 32'h400 + 32'(i);
         bus.pipe_we = 1'b1; bus.pipe_wR = 5'd21; bus.pipe_wD = 32'h300 + 32'(i);
         smp();
         if (i == 2) chk("t6_busy_queued", bus.busy1, 1'b1);
         next();
      end
      rst = 1'b1;
      idle();
      smp();
      chk("t6_rst_we", bus.we, 1'b0);
      chk("t6_rst_ready", bus.lu_ready, 1'b0);
      chk("t6_rst_busy", bus.busy1, 1'b0);
      chk("t6_rst_stall", bus.pipe_stall, 1'b0);
      next();
      rst = 1'b0;
      smp();
      chk("t6_post_ready", bus.lu_ready, 1'b1);
      chk("t6_post_busy", bus.busy1, 1'b0);
      chk("t6_post_we", bus.we, 1'b0);
      next();
      for (int i = 0; i < 3; i++) begin
         smp();
         chk("t6_post_no_write", bus.we, 1'b0);
         next();
      end

      chk("scoreboard_drained", 64'(exp_q.size()), 64'd0);
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
